// File: rtl/microsequencer_stack_pkg.sv
// Shared definitions for the microsequencer: next-address select encodings
// and the microword field layout.
//
// Microword layout, LSB first:
//   [2:0]                      ns_sel  next-address select
//   [3+SSW-1:3]                sts_sel status input select
//   [3+SSW]                    inv     invert selected status
//   [4+SSW+AW-1:4+SSW]         lit     literal target address
//   [MW-1:4+SSW+AW]            ctrl    datapath control field
package microsequencer_stack_pkg;

    typedef enum logic [2:0] {
        NS_ZERO   = 3'd0,
        NS_DECODE = 3'd1,
        NS_JUMP   = 3'd2,
        NS_INC    = 3'd3,
        NS_CJUMP  = 3'd4,
        NS_CALL   = 3'd5,
        NS_RET    = 3'd6,
        NS_WAIT   = 3'd7
    } ns_sel_e;

    localparam int NS_W    = 3;
    localparam int NS_LSB  = 0;
    localparam int STS_LSB = 3;

    function automatic int inv_pos(input int ssw);
        return 3 + ssw;
    endfunction

    function automatic int lit_lsb(input int ssw);
        return 4 + ssw;
    endfunction

    function automatic int ctrl_lsb(input int ssw, input int aw);
        return 4 + ssw + aw;
    endfunction

    function automatic int mw_width(input int ctrl_w, input int ssw, input int aw);
        return ctrl_w + 4 + ssw + aw;
    endfunction

    // Offsets for the default configuration (AW=8, SSW=2, CTRL_W=40).
    localparam int INV_POS_DEF  = 5;
    localparam int LIT_LSB_DEF  = 6;
    localparam int CTRL_LSB_DEF = 14;
    localparam int MW_DEF       = 54;

endpackage

// File: rtl/microsequencer_stack_if.sv
// Bus between the microsequencer and its surroundings (instruction encoder,
// status sources, combinational microstore).
//
// Signals:
//   mword        microword returned by the microstore for uaddr
//   decode_addr  entry address from the instruction encoder
//   sts          status inputs
//   stall        freeze the sequencer
//   uaddr        combinational address to the microstore
//   ctrl         control field of the word held in the pipeline register
//   CurrentState address of the word held in the pipeline register
//   stk_level    return-stack occupancy
//   stk_err      sticky stack overflow/underflow flag
//
// Transfer contract: there is no valid/ready pair. Every rising clock with
// stall low is a transfer: the word the microstore returns for uaddr is
// captured and becomes active (ctrl/CurrentState) after that edge. With
// stall high no transfer happens and uaddr shows the current address.
interface microsequencer_stack_if
    import microsequencer_stack_pkg::*;
#(
    parameter int AW        = 8,
    parameter int STS_N     = 4,
    parameter int SSW       = 2,
    parameter int STK_DEPTH = 4,
    parameter int CTRL_W    = 40
) ();
    localparam int MW    = mw_width(CTRL_W, SSW, AW);
    localparam int LVL_W = $clog2(STK_DEPTH + 1);

    logic [MW-1:0]     mword;
    logic [AW-1:0]     decode_addr;
    logic [STS_N-1:0]  sts;
    logic              stall;
    logic [AW-1:0]     uaddr;
    logic [CTRL_W-1:0] ctrl;
    logic [AW-1:0]     CurrentState;
    logic [LVL_W-1:0]  stk_level;
    logic              stk_err;

    // Sequencer side.
    modport slave (
        input  mword, decode_addr, sts, stall,
        output uaddr, ctrl, CurrentState, stk_level, stk_err
    );

    // Microstore / encoder side.
    modport master (
        output mword, decode_addr, sts, stall,
        input  uaddr, ctrl, CurrentState, stk_level, stk_err
    );
endinterface

// File: rtl/microsequencer_stack_return_stack.sv
// Return-address stack (LIFO) for subroutine calls.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low reset (clears occupancy only)
//   push_i   push data_i (caller must not push when full)
//   pop_i    pop top entry (caller must not pop when empty)
//   data_i   return address to push
//   top_o    top entry, 0 when empty
//   level_o  number of entries held
//   full_o   level_o == DEPTH
//   empty_o  level_o == 0
module return_stack #(
    parameter  int AW    = 8,
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH + 1),
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] data_i,
    output logic [AW-1:0] top_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [AW-1:0] mem_q [DEPTH];
    logic [LW-1:0] sp_q;
    logic [LW-1:0] sp_d;

    assign full_o  = (sp_q == LW'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign level_o = sp_q;
    assign top_o   = empty_o ? '0 : mem_q[IW'(sp_q - LW'(1))];

    always_comb begin
        sp_d = sp_q;
        if (push_i) begin
            sp_d = sp_q + LW'(1);
        end else if (pop_i) begin
            sp_d = sp_q - LW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry contents need no reset: only entries below sp are ever read.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[IW'(sp_q)] <= data_i;
        end
    end
endmodule

// File: rtl/microsequencer_stack.sv
// Microsequencer with a pipeline register and a hardware return-address
// stack. Computes the next microstore address from the word held in the
// pipeline register, the current address, status inputs and the encoder's
// entry address.
//
// Ports:
//   Clk    rising-edge clock
//   RESET  asynchronous active-low reset
//   bus    microsequencer_stack_if.slave (microword in, address/controls out)
module microsequencer_stack
    import microsequencer_stack_pkg::*;
#(
    parameter int AW        = 8,
    parameter int STS_N     = 4,
    parameter int SSW       = 2,
    parameter int STK_DEPTH = 4,
    parameter int CTRL_W    = 40
) (
    input logic                   Clk,
    input logic                   RESET,
    microsequencer_stack_if.slave bus
);
    localparam int MW       = mw_width(CTRL_W, SSW, AW);
    localparam int INV_POS  = inv_pos(SSW);
    localparam int LIT_LSB  = lit_lsb(SSW);
    localparam int CTRL_LSB = ctrl_lsb(SSW, AW);
    localparam int LVL_W    = $clog2(STK_DEPTH + 1);
    localparam int SEL_N    = 2 ** SSW;

    logic [MW-1:0]    pipe_q;
    logic [AW-1:0]    cur_q;
    logic             err_q, err_d;

    ns_sel_e          ns;
    logic [SSW-1:0]   sts_sel;
    logic             inv;
    logic [AW-1:0]    lit;
    logic [SEL_N-1:0] sts_ext;
    logic             s;
    logic [AW-1:0]    inc;
    logic [AW-1:0]    next;
    logic             push_req, pop_req;
    logic             push, pop;
    logic [AW-1:0]    top;
    logic [LVL_W-1:0] level;
    logic             full, empty;

    assign ns      = ns_sel_e'(pipe_q[NS_LSB +: NS_W]);
    assign sts_sel = pipe_q[STS_LSB +: SSW];
    assign inv     = pipe_q[INV_POS];
    assign lit     = pipe_q[LIT_LSB +: AW];

    // Zero-extend the status vector so selects beyond STS_N read as 0.
    assign sts_ext = SEL_N'(bus.sts);
    assign s       = sts_ext[sts_sel] ^ inv;
    assign inc     = cur_q + AW'(1);

    always_comb begin
        next     = '0;
        push_req = 1'b0;
        pop_req  = 1'b0;
        case (ns)
            NS_ZERO:   next = '0;
            NS_DECODE: next = bus.decode_addr;
            NS_JUMP:   next = lit;
            NS_INC:    next = inc;
            NS_CJUMP:  next = s ? lit : inc;
            NS_CALL: begin
                next     = lit;
                push_req = 1'b1;
            end
            NS_RET: begin
                // top reads 0 on an empty stack, giving the underflow target.
                next    = top;
                pop_req = 1'b1;
            end
            NS_WAIT:   next = s ? inc : cur_q;
            default:   next = '0;
        endcase
    end

    // Overflowing calls still jump; only the push is dropped.
    assign push  = !bus.stall && push_req && !full;
    assign pop   = !bus.stall && pop_req && !empty;
    assign err_d = err_q || (!bus.stall && ((push_req && full) || (pop_req && empty)));

    always_ff @(posedge Clk or negedge RESET) begin
        if (!RESET) begin
            pipe_q <= '0;
            cur_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (!bus.stall) begin
                pipe_q <= bus.mword;
                cur_q  <= next;
            end
            err_q <= err_d;
        end
    end

    return_stack #(
        .AW    (AW),
        .DEPTH (STK_DEPTH)
    ) u_stack (
        .clk_i   (Clk),
        .rst_ni  (RESET),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (inc),
        .top_o   (top),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.uaddr        = bus.stall ? cur_q : next;
    assign bus.ctrl         = pipe_q[CTRL_LSB +: CTRL_W];
    assign bus.CurrentState = cur_q;
    assign bus.stk_level    = level;
    assign bus.stk_err      = err_q;
endmodule

// File: tb/tb_microsequencer_stack.sv
module tb_microsequencer_stack;
    import microsequencer_stack_pkg::*;

    localparam int AW        = 8;
    localparam int STS_N     = 3;
    localparam int SSW       = 2;
    localparam int STK_DEPTH = 4;
    localparam int CTRL_W    = 40;
    localparam int MW        = CTRL_W + 4 + SSW + AW;

    // ---------------- clock / reset ----------------
    logic Clk   = 1'b0;
    logic RESET = 1'b0;
    always #5 Clk = ~Clk;

    microsequencer_stack_if #(
        .AW(AW), .STS_N(STS_N), .SSW(SSW), .STK_DEPTH(STK_DEPTH), .CTRL_W(CTRL_W)
    ) bus ();

    microsequencer_stack #(
        .AW(AW), .STS_N(STS_N), .SSW(SSW), .STK_DEPTH(STK_DEPTH), .CTRL_W(CTRL_W)
    ) dut (
        .Clk   (Clk),
        .RESET (RESET),
        .bus   (bus)
    );

    // Combinational microstore.
    logic [MW-1:0] mem [256];
    assign bus.mword = mem[bus.uaddr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [MW-1:0] mw(input logic [2:0] op, input int sel, input bit inv,
                                         input logic [7:0] lit, input logic [CTRL_W-1:0] ctrl);
        logic [1:0] sel2;
        sel2 = 2'(sel);
        return {ctrl, lit, inv, sel2, op};
    endfunction

    // ---------------- behavioural model + compare ----------------
    logic [MW-1:0] m_pipe, n_pipe;
    logic [AW-1:0] m_cur, n_cur, n_push_val;
    logic [AW-1:0] m_stack[$];
    bit            m_err, n_err;
    bit            pend = 0;
    int            n_act;   // 0 none, 1 push, 2 pop

    always @(negedge Clk) begin
        logic [2:0]        op;
        int                sel;
        bit                inv, sbit;
        logic [AW-1:0]     lit, inc, nxt, exp_u;
        logic [CTRL_W-1:0] m_ctrl;
        int                act;
        bit                err_next;
        if (!RESET) begin
            m_pipe = '0;
            m_cur  = '0;
            m_stack.delete();
            m_err  = 0;
            pend   = 0;
            check("rst_ctrl", bus.ctrl, 0);
            check("rst_cs", bus.CurrentState, 0);
            check("rst_lvl", bus.stk_level, 0);
            check("rst_err", bus.stk_err, 0);
        end else begin
            if (pend) begin
                m_pipe = n_pipe;
                m_cur  = n_cur;
                m_err  = n_err;
                if (n_act == 1) m_stack.push_back(n_push_val);
                if (n_act == 2) void'(m_stack.pop_back());
            end
            op     = m_pipe[2:0];
            sel    = int'(m_pipe[4:3]);
            inv    = m_pipe[5];
            lit    = m_pipe[13:6];
            m_ctrl = m_pipe[MW-1:14];
            sbit   = ((bus.sts >> sel) & 1) != 0;
            sbit   = sbit ^ inv;
            inc    = (m_cur == 8'hFF) ? 8'h00 : m_cur + 8'd1;
            act      = 0;
            err_next = m_err;
            case (op)
                3'd0: nxt = 8'h00;
                3'd1: nxt = bus.decode_addr;
                3'd2: nxt = lit;
                3'd3: nxt = inc;
                3'd4: nxt = sbit ? lit : inc;
                3'd5: begin
                    nxt = lit;
                    if (m_stack.size() < STK_DEPTH) act = 1;
                    else err_next = 1;
                end
                3'd6: begin
                    if (m_stack.size() == 0) begin
                        nxt = 8'h00;
                        err_next = 1;
                    end else begin
                        nxt = m_stack[$];
                        act = 2;
                    end
                end
                default: nxt = sbit ? inc : m_cur;
            endcase
            exp_u = bus.stall ? m_cur : nxt;
            check("uaddr", bus.uaddr, exp_u);
            check("ctrl", bus.ctrl, m_ctrl);
            check("cs", bus.CurrentState, m_cur);
            check("lvl", bus.stk_level, m_stack.size());
            check("err", bus.stk_err, m_err);
            if (bus.stall) begin
                pend = 0;
            end else begin
                pend       = 1;
                n_pipe     = mem[nxt];
                n_cur      = nxt;
                n_err      = err_next;
                n_act      = act;
                n_push_val = inc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic hold_reset();
        RESET = 1'b0;
        #1;
        check("imm_ctrl", bus.ctrl, 0);
        check("imm_cs", bus.CurrentState, 0);
        check("imm_uaddr", bus.uaddr, 0);
        check("imm_lvl", bus.stk_level, 0);
        check("imm_err", bus.stk_err, 0);
    endtask

    task automatic release_reset();
        tick();
        tick();
        RESET = 1'b1;
        check("rel_uaddr", bus.uaddr, 0);
    endtask

    // ---------------- directed stimulus ----------------
    logic [7:0] cs_tab  [12] = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50,
                                 8'h60, 8'h41, 8'h31, 8'h21, 8'h11, 8'h00};
    int         lvl_tab [12] = '{0, 0, 1, 2, 3, 4, 4, 3, 2, 1, 0, 0};
    int         err_tab [12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    logic [2:0] cj_sts  [4]  = '{3'b010, 3'b000, 3'b111, 3'b111};
    int         cj_sel  [4]  = '{1, 1, 3, 3};
    bit         cj_inv  [4]  = '{0, 0, 1, 0};
    logic [7:0] cj_exp  [4]  = '{8'h50, 8'h41, 8'h50, 8'h41};

    initial begin
        bus.stall       = 1'b0;
        bus.sts         = '0;
        bus.decode_addr = '0;
        clear_mem();

        // Decode and increment.
        hold_reset();
        mem[8'h00] = mw(NS_DECODE, 0, 0, 8'h00, 40'hA5A5);
        mem[8'h21] = mw(NS_INC, 0, 0, 8'h00, 40'h21);
        mem[8'h22] = mw(NS_JUMP, 0, 0, 8'h22, 40'h22);
        bus.decode_addr = 8'h21;
        release_reset();
        tick();
        check("first_cs", bus.CurrentState, 8'h00);
        check("first_ctrl", bus.ctrl, 40'hA5A5);
        check("dec_uaddr", bus.uaddr, 8'h21);
        tick();
        check("dec_cs", bus.CurrentState, 8'h21);
        check("dec_ctrl", bus.ctrl, 40'h21);
        tick();
        check("inc_cs", bus.CurrentState, 8'h22);
        tick();

        // Wait on MOC, both polarities.
        for (int v = 0; v < 2; v++) begin
            hold_reset();
            clear_mem();
            mem[8'h00] = mw(NS_JUMP, 0, 0, 8'h30, 40'h0);
            mem[8'h30] = mw(NS_WAIT, 0, v[0], 8'h00, 40'h30);
            mem[8'h31] = mw(NS_JUMP, 0, 0, 8'h31, 40'h31);
            bus.sts = (v == 1) ? 3'b001 : 3'b000;
            release_reset();
            tick();
            tick();
            check("wait_enter", bus.CurrentState, 8'h30);
            for (int k = 0; k < 3; k++) begin
                tick();
                check("wait_hold", bus.CurrentState, 8'h30);
            end
            bus.sts = (v == 1) ? 3'b000 : 3'b001;
            tick();
            check("wait_exit", bus.CurrentState, 8'h31);
        end

        // Conditional jump, including out-of-range status select.
        for (int c = 0; c < 4; c++) begin
            hold_reset();
            clear_mem();
            mem[8'h00] = mw(NS_JUMP, 0, 0, 8'h40, 40'h0);
            mem[8'h40] = mw(NS_CJUMP, cj_sel[c], cj_inv[c], 8'h50, 40'h40);
            mem[8'h41] = mw(NS_JUMP, 0, 0, 8'h41, 40'h41);
            mem[8'h50] = mw(NS_JUMP, 0, 0, 8'h50, 40'h50);
            bus.sts = cj_sts[c];
            release_reset();
            tick();
            tick();
            tick();
            check("cjump_cs", bus.CurrentState, cj_exp[c]);
        end
        bus.sts = '0;

        // Nested call / return with overflow and underflow.
        hold_reset();
        clear_mem();
        mem[8'h00] = mw(NS_JUMP, 0, 0, 8'h10, 40'h0);
        mem[8'h10] = mw(NS_CALL, 0, 0, 8'h20, 40'h10);
        mem[8'h20] = mw(NS_CALL, 0, 0, 8'h30, 40'h20);
        mem[8'h30] = mw(NS_CALL, 0, 0, 8'h40, 40'h30);
        mem[8'h40] = mw(NS_CALL, 0, 0, 8'h50, 40'h40);
        mem[8'h50] = mw(NS_CALL, 0, 0, 8'h60, 40'h50);
        mem[8'h60] = mw(NS_RET, 0, 0, 8'h00, 40'h60);
        mem[8'h41] = mw(NS_RET, 0, 0, 8'h00, 40'h41);
        mem[8'h31] = mw(NS_RET, 0, 0, 8'h00, 40'h31);
        mem[8'h21] = mw(NS_RET, 0, 0, 8'h00, 40'h21);
        mem[8'h11] = mw(NS_RET, 0, 0, 8'h00, 40'h11);
        release_reset();
        for (int i = 0; i < 12; i++) begin
            tick();
            check("call_cs", bus.CurrentState, cs_tab[i]);
            check("call_lvl", bus.stk_level, lvl_tab[i]);
            check("call_err", bus.stk_err, err_tab[i]);
        end

        // Stall during a CALL, then wrap from 0xFF.
        hold_reset();
        clear_mem();
        mem[8'h00] = mw(NS_JUMP, 0, 0, 8'h10, 40'h0);
        mem[8'h10] = mw(NS_CALL, 0, 0, 8'h20, 40'h10);
        mem[8'h20] = mw(NS_JUMP, 0, 0, 8'hFF, 40'h20);
        mem[8'hFF] = mw(NS_INC, 0, 0, 8'h00, 40'hFF);
        release_reset();
        tick();
        tick();
        check("pre_stall_cs", bus.CurrentState, 8'h10);
        bus.stall = 1'b1;
        #1;
        check("stall_uaddr", bus.uaddr, 8'h10);
        for (int k = 0; k < 2; k++) begin
            tick();
            check("stall_cs", bus.CurrentState, 8'h10);
            check("stall_lvl", bus.stk_level, 0);
            check("stall_uaddr", bus.uaddr, 8'h10);
        end
        bus.stall = 1'b0;
        #1;
        check("unstall_uaddr", bus.uaddr, 8'h20);
        tick();
        check("post_call_cs", bus.CurrentState, 8'h20);
        check("post_call_lvl", bus.stk_level, 1);
        tick();
        check("at_ff_cs", bus.CurrentState, 8'hFF);
        tick();
        check("wrap_cs", bus.CurrentState, 8'h00);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end
endmodule

// File: doc/microsequencer_stack.md
Name: microsequencer_stack

Overview:
- Parametrised successor to the control unit's next-state path: microsequencer with internal pipeline register and a hardware return-address stack.
- Sits between the instruction encoder and an external combinational microstore.
- Generalises the address width, status-input count and microword width.
- Adds conditional jump, subroutine call and return, a wait-on-status mode, and a global stall.

Parameters:
- AW, 8, microstore address width.
- STS_N, 4, number of status inputs (MOC, COND, IR[13], IR[23], ...).
- SSW, 2, status-select field width; requires 2^SSW >= STS_N.
- STK_DEPTH, 4, return-stack entries (>=1).
- CTRL_W, 40, width of datapath control field passed through.
- MW, CTRL_W+3+SSW+1+AW, microword width (derived).

Ports:
- Clk  in  1  rising-edge clock
- RESET  in  1  asynchronous reset, active-low
- mword  in  MW  microword read from microstore at uaddr
- decode_addr  in  AW  entry address from instruction encoder
- sts  in  STS_N  status inputs
- stall  in  1  freeze sequencer
- uaddr  out  AW  combinational address to microstore
- ctrl  out  CTRL_W  pipe[MW-1:MW-CTRL_W], datapath controls
- CurrentState  out  AW  address of the word held in pipe
- stk_level  out  clog2(STK_DEPTH+1)  stack occupancy
- stk_err  out  1  sticky overflow/underflow flag

Behaviour:
- Microword fields, LSB first:
  - ns_sel [2:0]
  - sts_sel [3+SSW-1:3]
  - inv [3+SSW]
  - lit [4+SSW+AW-1:4+SSW]
  - ctrl above lit
- Registers: pipe (MW), cur (AW), stack[STK_DEPTH] (AW), sp, stk_err.
- RESET low: pipe=0, cur=0, sp=0, stk_err=0 immediately. ctrl=0, CurrentState=0.
- s = sts[sts_sel] ^ inv; sts_sel >= STS_N reads 0 (then s=inv).
- inc = cur+1 mod 2^AW (wraps 2^AW-1 -> 0).
- next by ns_sel:
  - 0 ZERO: 0
  - 1 DECODE: decode_addr
  - 2 JUMP: lit
  - 3 INC: inc
  - 4 CJUMP: s ? lit : inc
  - 5 CALL: lit; push inc
  - 6 RET: top of stack; pop
  - 7 WAIT: s ? inc : cur (self-loop, e.g. on MOC)
- uaddr = stall ? cur : next (combinational).
- Rising Clk, stall=0: pipe<=mword, cur<=next, stack update. Stall=1: all registers hold, including stk_err; no push/pop.
- Latency: one cycle from address to pipe. A word becomes active the edge after its address appears on uaddr.
- After reset release uaddr=0 (pipe=0 decodes ZERO). The first edge loads word 0 with CurrentState=0.
- CALL with sp==STK_DEPTH: jump still taken, push dropped, stk_err<=1.
- RET with sp==0: next=0, stk_err<=1, sp stays 0.
- stk_err clears only on RESET.
- RESET asserted mid-operation: stack contents don't care, sp=0.

Decomposition:
- Shared package holds:
  - ns_sel encodings NS_ZERO..NS_WAIT (3-bit)
  - field-offset localparams derived from AW/SSW/CTRL_W
- One sub-module, return_stack: push, pop, top, level, full, empty; async active-low reset.

Test Plan:
- Reset/fetch: RESET low mid-run, then release.
  - Immediately: ctrl=0, CurrentState=0, uaddr=0.
  - After first edge: pipe=mword@0.
- Decode and increment: word0 DECODE, decode_addr=0x21.
  - CurrentState sequence 0 -> 0x21 -> 0x22 with word@0x21 INC.
- Wait handshake: word@0x30 WAIT sts_sel=0 (MOC), inv=0.
  - MOC=0 for 3 cycles: CurrentState held at 0x30.
  - MOC=1: next CurrentState 0x31.
  - Same with inv=1: exits on MOC=0.
- Conditional jump: CJUMP lit=0x50, sts_sel=1.
  - COND=1 -> 0x50.
  - COND=0 -> cur+1.
  - sts_sel=3 with STS_N=3 behaves as s=inv.
- Nested call/return, STK_DEPTH=4:
  - Four CALLs from 0x10/0x20/0x30/0x40 -> stk_level=4.
  - A fifth CALL still jumps, stk_err=1.
  - Four RETs return to 0x41, 0x31, 0x21, 0x11.
  - A fifth RET -> 0x00.
- Stall and wrap:
  - stall=1 for 2 cycles during CALL: no push, stk_level unchanged, uaddr=cur.
  - INC at cur=0xFF -> 0x00.
